// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared types and constants for the 256x23 single-port SRAM requester-side controller.
package ct_spsram_ctrl_pkg;

  localparam int CT_ADDR_W    = 8;
  localparam int CT_DATA_W    = 23;
  localparam int CT_RSP_DEPTH = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Round-robin pointer: which side wins the next contested cycle.
  typedef enum logic {
    SIDE_RD = 1'b0,
    SIDE_WR = 1'b1
  } side_e;

  // Idle SRAM drive: chip disabled, read mode, all bit-writes masked.
  localparam logic SRAM_CEN_IDLE  = 1'b1;
  localparam logic SRAM_GWEN_IDLE = 1'b1;

endpackage

// File: rtl/ct_spsram_rsp_fifo.sv
// Synchronous read-response FIFO with occupancy count; head entry is presented combinationally.
module ct_spsram_rsp_fifo #(
  parameter int DATA_WIDTH = 23,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  localparam int                PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]     LAST    = PW'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only observable once count marks them valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);

endmodule

// File: rtl/ct_spsram_256x23_ctrl.sv
// Arbitrates read/write valid-ready ports onto one SRAM port, queues read data, zero-fills after reset.
module ct_spsram_256x23_ctrl
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = CT_ADDR_W,
  parameter int DATA_WIDTH = CT_DATA_W,
  parameter int RSP_DEPTH  = CT_RSP_DEPTH,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_vld,
  output logic                  wr_rdy,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  input  logic                  rd_vld,
  output logic                  rd_rdy,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_done,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int                    CW       = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0]           DEPTH_C  = (CW + 1)'(RSP_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  inflight_q;
  side_e                 rr_q;

  logic                  run;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW:0]           occupancy;
  logic                  rd_elig;
  logic                  contested;
  logic                  wr_gnt;
  logic                  rd_gnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= INIT_EN ? ST_INIT : ST_RUN;
      init_cnt_q <= '0;
      inflight_q <= 1'b0;
      rr_q       <= SIDE_RD;
    end else begin
      state_q    <= state_d;
      if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
      inflight_q <= rd_gnt;
      if (contested) rr_q <= wr_gnt ? SIDE_RD : SIDE_WR;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && init_cnt_q == CNT_LAST) state_d = ST_RUN;
  end

  assign run = (state_q == ST_RUN) && !RST;

  // A read is only granted if its response is guaranteed a FIFO slot; a same-cycle pop is not counted.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign rd_elig   = rd_vld && (occupancy < DEPTH_C);
  assign contested = run && wr_vld && rd_elig;

  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (contested) begin
      wr_gnt = (rr_q == SIDE_WR);
      rd_gnt = (rr_q == SIDE_RD);
    end else if (run) begin
      wr_gnt = wr_vld;
      rd_gnt = rd_elig;
    end
  end

  always_comb begin
    sram_cen  = SRAM_CEN_IDLE;
    sram_gwen = SRAM_GWEN_IDLE;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (!RST && state_q == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt_q;
    end else if (wr_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~wr_mask;
      sram_a    = wr_addr;
      sram_d    = wr_data;
    end else if (rd_gnt) begin
      sram_cen  = 1'b0;
      sram_a    = rd_addr;
    end
  end

  assign wr_rdy    = wr_gnt;
  assign rd_rdy    = rd_gnt;
  assign init_done = run;
  assign rsp_vld   = !fifo_empty && !RST;

  ct_spsram_rsp_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (RSP_DEPTH),
    .CNT_W     (CW)
  ) u_rsp_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (inflight_q && !fifo_full),
    .push_data(sram_q),
    .pop      (rsp_vld && rsp_rdy),
    .pop_data (rsp_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_ct_spsram_256x23_ctrl.sv
// Directed bench: two controller instances (zero-fill on / off), each with a behavioural 256x23 SRAM.
module tb_ct_spsram_256x23_ctrl;

  localparam logic [22:0] FULL = 23'h7FFFFF;
  localparam logic [22:0] D1   = 23'h123456;
  localparam logic [22:0] D2   = 23'h654321;
  localparam logic [22:0] D3   = 23'h0ABCDE;
  localparam logic [22:0] DB   = 23'h1ABCDE;
  localparam logic [22:0] M10  = 23'h7FFF00;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // Zero-fill instance
  logic        wr_vld = 0, wr_rdy, rd_vld = 0, rd_rdy, rsp_vld, rsp_rdy = 0, init_done;
  logic [7:0]  wr_addr = 0, rd_addr = 0, sram_a;
  logic [22:0] wr_data = 0, wr_mask = 0, rsp_data, sram_wen, sram_d, sram_q;
  logic        sram_cen, sram_gwen;
  // No-zero-fill instance
  logic        wr_vld_b = 0, wr_rdy_b, rd_vld_b = 0, rd_rdy_b, rsp_vld_b, rsp_rdy_b = 0, init_done_b;
  logic [7:0]  wr_addr_b = 0, rd_addr_b = 0, sram_a_b;
  logic [22:0] wr_data_b = 0, wr_mask_b = 0, rsp_data_b, sram_wen_b, sram_d_b, sram_q_b;
  logic        sram_cen_b, sram_gwen_b;

  ct_spsram_256x23_ctrl #(.INIT_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_addr(rd_addr),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .init_done(init_done),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen), .sram_a(sram_a),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  ct_spsram_256x23_ctrl #(.INIT_EN(1'b0)) dut_b (
    .CLK(CLK), .RST(RST),
    .wr_vld(wr_vld_b), .wr_rdy(wr_rdy_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_mask(wr_mask_b),
    .rd_vld(rd_vld_b), .rd_rdy(rd_rdy_b), .rd_addr(rd_addr_b),
    .rsp_vld(rsp_vld_b), .rsp_rdy(rsp_rdy_b), .rsp_data(rsp_data_b), .init_done(init_done_b),
    .sram_cen(sram_cen_b), .sram_gwen(sram_gwen_b), .sram_wen(sram_wen_b), .sram_a(sram_a_b),
    .sram_d(sram_d_b), .sram_q(sram_q_b)
  );

  // Behavioural SRAMs: write lands at the edge, Q valid the cycle after a read.
  logic [22:0] mem_a [256];
  logic [22:0] mem_b [256];

  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem_a[sram_a] <= (mem_a[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem_a[sram_a];
    end
  end

  always @(posedge CLK) begin
    if (!sram_cen_b) begin
      if (!sram_gwen_b) mem_b[sram_a_b] <= (mem_b[sram_a_b] & sram_wen_b) | (sram_d_b & ~sram_wen_b);
      else              sram_q_b <= mem_b[sram_a_b];
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge CLK);
    check(name, {wr_rdy, rd_rdy, rsp_vld, init_done, sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
          {4'b0000, 1'b1, 1'b1, FULL, 8'h00, 23'h0});
    check({name, "_b"}, {init_done_b, rsp_vld_b, sram_cen_b}, {1'b0, 1'b0, 1'b1});
  endtask

  // Expects a fresh zero-fill sweep starting in the current cycle.
  task automatic run_init_check(input string name);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a_exp;
      a_exp = i[7:0];
      @(negedge CLK);
      check(name, {sram_cen, sram_gwen, sram_wen, sram_a, sram_d, init_done, rsp_vld, wr_rdy, rd_rdy},
            {1'b0, 1'b0, 23'h0, a_exp, 23'h0, 4'b0000});
      step();
    end
    @(negedge CLK);
    check({name, "_done"}, {init_done, sram_cen}, {1'b1, 1'b1});
    step();
  endtask

  // Zero-fill disabled: usable in the first cycle, nothing written on its own.
  task automatic dut_b_seq();
    @(negedge CLK);
    check("b_first_cycle", {init_done_b, sram_cen_b, wr_rdy_b, rd_rdy_b}, {1'b1, 1'b1, 1'b0, 1'b0});
    step();
    wr_vld_b = 1; wr_addr_b = 8'h33; wr_data_b = DB; wr_mask_b = FULL;
    @(negedge CLK);
    check("b_write", {wr_rdy_b, sram_cen_b, sram_gwen_b, sram_a_b}, {1'b1, 1'b0, 1'b0, 8'h33});
    step();
    wr_vld_b = 0; rd_vld_b = 1; rd_addr_b = 8'h33; rsp_rdy_b = 1;
    @(negedge CLK);
    check("b_read", {rd_rdy_b, sram_gwen_b}, {1'b1, 1'b1});
    step();
    rd_vld_b = 0;
    @(negedge CLK);
    check("b_rsp_lat1", rsp_vld_b, 1'b0);
    step();
    @(negedge CLK);
    check("b_rsp", {rsp_vld_b, rsp_data_b}, {1'b1, DB});
    step();
    @(negedge CLK);
    check("b_rsp_empty", rsp_vld_b, 1'b0);
  endtask

  typedef struct {
    logic        wv;
    logic [7:0]  wa;
    logic [22:0] wd;
    logic [22:0] wm;
    logic        rv;
    logic [7:0]  ra;
    logic        rr;
    logic        e_wrdy;
    logic        e_rrdy;
    logic        e_rvld;
    logic [22:0] e_data;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic [7:0]  t4_addr [4];
    logic [22:0] t4_data [5];

    // wv  wa     wd       wm            rv  ra     rr   ewr eRr eV  edata
    vecs[0]  = '{1'b0, 8'h00, 23'h0, 23'h0,      1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 23'h0};
    vecs[1]  = '{1'b0, 8'h00, 23'h0, 23'h0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 23'h0};
    vecs[2]  = '{1'b0, 8'h00, 23'h0, 23'h0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 23'h0};
    vecs[3]  = '{1'b1, 8'h10, FULL,  FULL,       1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 23'h0};
    vecs[4]  = '{1'b1, 8'h10, 23'h0, 23'h0000FF, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 23'h0};
    vecs[5]  = '{1'b0, 8'h00, 23'h0, 23'h0,      1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 23'h0};
    vecs[6]  = '{1'b0, 8'h00, 23'h0, 23'h0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 23'h0};
    vecs[7]  = '{1'b0, 8'h00, 23'h0, 23'h0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, M10};
    vecs[8]  = '{1'b1, 8'h20, D1,    FULL,       1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 23'h0};
    vecs[9]  = '{1'b1, 8'h20, D1,    FULL,       1'b1, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0, 23'h0};
    vecs[10] = '{1'b1, 8'h30, D2,    FULL,       1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 1'b1, M10};
    vecs[11] = '{1'b1, 8'h30, D2,    FULL,       1'b1, 8'h30, 1'b1, 1'b1, 1'b0, 1'b0, 23'h0};
    vecs[12] = '{1'b1, 8'h40, D3,    FULL,       1'b1, 8'h30, 1'b1, 1'b0, 1'b1, 1'b1, D1};
    vecs[13] = '{1'b1, 8'h40, D3,    FULL,       1'b1, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0, 23'h0};
    vecs[14] = '{1'b0, 8'h00, 23'h0, 23'h0,      1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 1'b1, D2};
    vecs[15] = '{1'b0, 8'h00, 23'h0, 23'h0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 23'h0};
    vecs[16] = '{1'b0, 8'h00, 23'h0, 23'h0,      1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, D3};

    t4_addr = '{8'h10, 8'h20, 8'h30, 8'h40};
    t4_data = '{M10, D1, D2, D3, M10};

    // Power-on reset
    check_reset_outputs("por0");
    step();
    check_reset_outputs("por1");
    step();
    RST = 0;

    fork
      run_init_check("init1");
      dut_b_seq();
    join

    // Single reads, masked writes, contested arbitration
    for (int i = 0; i < 17; i++) begin
      wr_vld = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd; wr_mask = vecs[i].wm;
      rd_vld = vecs[i].rv; rd_addr = vecs[i].ra; rsp_rdy = vecs[i].rr;
      @(negedge CLK);
      check($sformatf("vec%0d_rdy", i), {wr_rdy, rd_rdy, rsp_vld},
            {vecs[i].e_wrdy, vecs[i].e_rrdy, vecs[i].e_rvld});
      if (vecs[i].e_rvld) check($sformatf("vec%0d_data", i), rsp_data, vecs[i].e_data);
      step();
    end
    wr_vld = 0; rd_vld = 0;

    // Backpressure: four reads fill the response queue, then it drains in order
    rsp_rdy = 0;
    for (int c = 0; c < 8; c++) begin
      rd_vld  = 1;
      rd_addr = (c < 4) ? t4_addr[c] : 8'h10;
      @(negedge CLK);
      check($sformatf("bp_rd_rdy%0d", c), rd_rdy, (c < 4));
      if (c >= 2) check($sformatf("bp_hold%0d", c), {rsp_vld, rsp_data}, {1'b1, M10});
      step();
    end
    rsp_rdy = 1;
    rd_addr = 8'h10;
    for (int p = 0; p < 6; p++) begin
      @(negedge CLK);
      if (p == 0) check("bp_rd_rdy_before_pop", rd_rdy, 1'b0);
      if (p == 1) check("bp_rd_rdy_after_pop", rd_rdy, 1'b1);
      if (p < 5) check($sformatf("bp_drain%0d", p), {rsp_vld, rsp_data}, {1'b1, t4_data[p]});
      else       check("bp_drained", rsp_vld, 1'b0);
      step();
      if (p == 1) rd_vld = 0;
    end

    // Mid-operation reset with two queued responses and one in flight
    rsp_rdy = 0;
    for (int c = 0; c < 3; c++) begin
      rd_vld  = 1;
      rd_addr = t4_addr[c + 1];
      @(negedge CLK);
      check($sformatf("mr_rd%0d", c), rd_rdy, 1'b1);
      step();
    end
    rd_vld = 0;
    RST    = 1;
    check_reset_outputs("mr_rst0");
    step();
    check_reset_outputs("mr_rst1");
    step();
    RST     = 0;
    rsp_rdy = 1;
    run_init_check("init2");
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      check($sformatf("mr_no_stale%0d", c), rsp_vld, 1'b0);
      step();
    end

    // Zero-fill overwrote the earlier D3 at 0x40
    rd_vld = 1; rd_addr = 8'h40;
    @(negedge CLK);
    check("zf_rd", rd_rdy, 1'b1);
    step();
    rd_vld = 0;
    step();
    @(negedge CLK);
    check("zf_data", {rsp_vld, rsp_data}, {1'b1, 23'h0});
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
